// File: rtl/intra4x4_mode_sched_pkg.sv
// Shared definitions for the Intra4x4 mode-decision sequencer: mode numbering,
// widths, FSM states and the neighbour-availability to mode-mask mapping.
package intra_pkg;

   localparam int MODE_W    = 4;
   localparam int SAD_W     = 12;
   localparam int NUM_MODES = 9;

   localparam logic [MODE_W-1:0] MODE_V   = 4'd0;
   localparam logic [MODE_W-1:0] MODE_H   = 4'd1;
   localparam logic [MODE_W-1:0] MODE_DC  = 4'd2;
   localparam logic [MODE_W-1:0] MODE_DDL = 4'd3;
   localparam logic [MODE_W-1:0] MODE_DDR = 4'd4;
   localparam logic [MODE_W-1:0] MODE_VR  = 4'd5;
   localparam logic [MODE_W-1:0] MODE_HD  = 4'd6;
   localparam logic [MODE_W-1:0] MODE_VL  = 4'd7;
   localparam logic [MODE_W-1:0] MODE_HU  = 4'd8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Bit m of the result is set when mode m has every neighbour it reads.
   function automatic logic [NUM_MODES-1:0] avail_mask(input logic top,
                                                       input logic left,
                                                       input logic topleft);
      logic [NUM_MODES-1:0] m;
      m           = '0;
      m[MODE_V]   = top;
      m[MODE_H]   = left;
      m[MODE_DC]  = 1'b1;
      m[MODE_DDL] = top;
      m[MODE_DDR] = top & left & topleft;
      m[MODE_VR]  = top & left & topleft;
      m[MODE_HD]  = top & left & topleft;
      m[MODE_VL]  = top;
      m[MODE_HU]  = left;
      return m;
   endfunction

endpackage

// File: rtl/intra4x4_next_mode.sv
// Combinational search for the lowest allowed mode above the current one;
// from_start=1 searches from the bottom, as if current were -1.
module intra4x4_next_mode #(
   parameter int MODE_W = intra_pkg::MODE_W
) (
   input  logic [intra_pkg::NUM_MODES-1:0] mask,
   input  logic                            from_start,
   input  logic [MODE_W-1:0]               cur,
   output logic [MODE_W-1:0]               nxt,
   output logic                            none
);
   import intra_pkg::*;

   // Descending scan so the last hit, i.e. the lowest qualifying mode, wins.
   always_comb begin
      nxt  = '0;
      none = 1'b1;
      for (int i = NUM_MODES - 1; i >= 0; i--) begin
         if (mask[i] && (from_start || (i > int'(cur)))) begin
            nxt  = MODE_W'(i);
            none = 1'b0;
         end
      end
   end

endmodule

// File: rtl/intra4x4_mode_sched.sv
// Intra4x4 mode-decision sequencer: issues each allowed mode in ascending order,
// collects one SAD per mode and keeps the lowest (ties favour the lower mode).
module intra4x4_mode_sched #(
   parameter int SAD_W  = intra_pkg::SAD_W,
   parameter int MODE_W = intra_pkg::MODE_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              avail_top,
   input  logic              avail_left,
   input  logic              avail_topleft,
   output logic [MODE_W-1:0] mode_sel,
   output logic              mode_valid,
   input  logic              sad_valid,
   input  logic [SAD_W-1:0]  sad_in,
   output logic              busy,
   output logic              done,
   output logic [MODE_W-1:0] best_mode,
   output logic [SAD_W-1:0]  best_sad
);
   import intra_pkg::*;

   state_t                 state;
   logic [NUM_MODES-1:0]   mask_q;
   logic                   first_q;
   logic [NUM_MODES-1:0]   live_mask;
   logic [MODE_W-1:0]      first_mode;
   logic                   first_none;
   logic [MODE_W-1:0]      next_mode;
   logic                   next_none;

   assign live_mask = avail_mask(avail_top, avail_left, avail_topleft);

   intra4x4_next_mode #(.MODE_W(MODE_W)) u_first (
      .mask       (live_mask),
      .from_start (1'b1),
      .cur        ('0),
      .nxt        (first_mode),
      .none       (first_none)
   );

   intra4x4_next_mode #(.MODE_W(MODE_W)) u_next (
      .mask       (mask_q),
      .from_start (1'b0),
      .cur        (mode_sel),
      .nxt        (next_mode),
      .none       (next_none)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         mode_sel   <= '0;
         mode_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         best_mode  <= '0;
         best_sad   <= '0;
         mask_q     <= '0;
         first_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  mask_q     <= live_mask;
                  first_q    <= 1'b1;
                  // DC is always in the mask; the fallback only guards odd widths.
                  mode_sel   <= first_none ? MODE_W'(MODE_DC) : first_mode;
                  mode_valid <= 1'b1;
                  busy       <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               mode_valid <= 1'b0;
               state      <= WAIT;
            end
            WAIT: begin
               if (sad_valid) begin
                  if (first_q || (sad_in < best_sad)) begin
                     best_sad  <= sad_in;
                     best_mode <= mode_sel;
                  end
                  first_q <= 1'b0;
                  if (!next_none) begin
                     mode_sel   <= next_mode;
                     mode_valid <= 1'b1;
                     state      <= ISSUE;
                  end else begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
